// File: rtl/mult4_seq_pkg.sv
// rtl/mult4_seq_pkg.sv - shared types and defaults for the sequential shift-add multiplier
package mult4_seq_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult4_seq_if.sv
// rtl/mult4_seq_if.sv - start/busy/done handshake and operand/product bundle
interface mult4_seq_if #(parameter int WIDTH = mult4_seq_pkg::WIDTH_DEF) ();

    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     p;

    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);

endinterface

// File: rtl/mult4_seq_adder_ripple_c.sv
// rtl/mult4_seq_adder_ripple_c.sv - full adder cell and WIDTH-bit ripple-carry adder with carry out
module fulladd (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

module adder_ripple_c
    import mult4_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] c;

    // Carry-in is fixed at zero: the multiplier only ever needs a plain add.
    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        fulladd u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/mult4_seq.sv
// rtl/mult4_seq.sv - sequential unsigned shift-add multiplier reusing one ripple-carry adder
module mult4_seq
    import mult4_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    mult4_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t               st_q, st_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     h_q, h_d;
    logic [WIDTH-1:0]     l_q, l_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 carry;
    logic [WIDTH-1:0]     h_step;
    logic [WIDTH-1:0]     l_step;

    assign addend = l_q[0] ? m_q : '0;

    adder_ripple_c #(.WIDTH(WIDTH)) u_add (
        .x    (h_q),
        .y    (addend),
        .s    (sum),
        .cout (carry)
    );

    // The carry shifts into the top of H, so the running sum never overflows.
    assign h_step = {carry, sum[WIDTH-1:1]};
    assign l_step = {sum[0], l_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q  <= IDLE;
            m_q   <= '0;
            h_q   <= '0;
            l_q   <= '0;
            cnt_q <= '0;
            p_q   <= '0;
        end else begin
            st_q  <= st_d;
            m_q   <= m_d;
            h_q   <= h_d;
            l_q   <= l_d;
            cnt_q <= cnt_d;
            p_q   <= p_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        m_d   = m_q;
        h_d   = h_q;
        l_d   = l_q;
        cnt_d = cnt_q;
        p_d   = p_q;
        case (st_q)
            IDLE: begin
                if (bus.start) begin
                    m_d   = bus.a;
                    l_d   = bus.b;
                    h_d   = '0;
                    cnt_d = '0;
                    st_d  = CALC;
                end
            end
            CALC: begin
                h_d   = h_step;
                l_d   = l_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    p_d  = {h_step, l_step};
                    st_d = DONE;
                end
            end
            DONE: st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    assign bus.busy = (st_q != IDLE);
    assign bus.done = (st_q == DONE);
    assign bus.p    = p_q;

endmodule

// File: tb/tb_mult4_seq.sv
// tb/tb_mult4_seq.sv - randomized self-checking bench for mult4_seq against an arithmetic model
module tb_mult4_seq;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    logic [7:0] exp_p = 8'd0;

    mult4_seq_if bus ();

    mult4_seq dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Presents operands with START for exactly one accepting edge; returns at the negedge after it.
    task automatic launch(input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        bus.a = av;
        bus.b = bv;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Observes one operation from the negedge after acceptance until BUSY drops.
    task automatic watch(input logic [7:0] prev, output int done_at, output int busy_cnt,
                         output logic [7:0] p_done, output bit held);
        done_at = -1;
        busy_cnt = 0;
        held = 1'b1;
        p_done = 8'hxx;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            if (!bus.busy) break;
            busy_cnt++;
            if (bus.done && done_at < 0) begin
                done_at = j;
                p_done = bus.p;
            end
            if (done_at < 0 && bus.p !== prev) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else passed++;
        checks++; if (bus.p !== 8'd0) $display("FAIL reset_p got %0d exp 0", bus.p); else passed++;
        rstn = 1'b1;
        exp_p = 8'd0;
    endtask

    task automatic test_max;
        int done_at, busy_cnt;
        logic [7:0] pd;
        bit held;
        launch(4'd15, 4'd15);
        watch(exp_p, done_at, busy_cnt, pd, held);
        checks++; if (busy_cnt != 5) $display("FAIL max_busy_cycles got %0d exp 5", busy_cnt); else passed++;
        checks++; if (done_at != 4) $display("FAIL max_done_latency got %0d exp 4", done_at); else passed++;
        checks++; if (pd !== 8'hE1) $display("FAIL max_product got %0d exp 225", pd); else passed++;
        checks++; if (!held) $display("FAIL max_p_held got 0 exp 1"); else passed++;
        exp_p = 8'hE1;
    endtask

    task automatic test_pair_hold;
        logic [3:0] av[2] = '{4'd3, 4'd0};
        logic [3:0] bv[2] = '{4'd5, 4'd9};
        int done_at, busy_cnt;
        logic [7:0] pd;
        bit held;
        for (int i = 0; i < 2; i++) begin
            launch(av[i], bv[i]);
            watch(exp_p, done_at, busy_cnt, pd, held);
            checks++; if (done_at != 4) $display("FAIL pair%0d_latency got %0d exp 4", i, done_at); else passed++;
            checks++; if (pd !== 8'(av[i] * bv[i])) $display("FAIL pair%0d_product got %0d exp %0d", i, pd, av[i] * bv[i]); else passed++;
            checks++; if (!held) $display("FAIL pair%0d_p_held got 0 exp 1 (prev %0d)", i, exp_p); else passed++;
            exp_p = 8'(av[i] * bv[i]);
        end
    endtask

    task automatic test_ignore_start;
        int done_at = -1;
        launch(4'd6, 4'd7);
        bus.start = 1'b1;
        bus.a = 4'd15;
        bus.b = 4'd15;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            if (bus.done) begin
                done_at = j;
                break;
            end
        end
        checks++; if (done_at != 4) $display("FAIL ignore_latency got %0d exp 4", done_at); else passed++;
        checks++; if (bus.p !== 8'd42) $display("FAIL ignore_product got %0d exp 42", bus.p); else passed++;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) $display("FAIL ignore_done_start got busy %b exp 0", bus.busy); else passed++;
        checks++; if (bus.p !== 8'd42) $display("FAIL ignore_p_hold got %0d exp 42", bus.p); else passed++;
        exp_p = 8'd42;
    endtask

    task automatic test_abort;
        int done_at, busy_cnt;
        logic [7:0] pd;
        bit held;
        launch(4'd7, 4'd6);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL abort_done got %b exp 0", bus.done); else passed++;
        checks++; if (bus.p !== 8'd0) $display("FAIL abort_p got %0d exp 0", bus.p); else passed++;
        @(negedge clk);
        rstn = 1'b1;
        exp_p = 8'd0;
        launch(4'd5, 4'd3);
        watch(exp_p, done_at, busy_cnt, pd, held);
        checks++; if (done_at != 4) $display("FAIL abort_rerun_latency got %0d exp 4", done_at); else passed++;
        checks++; if (pd !== 8'd15) $display("FAIL abort_rerun_product got %0d exp 15", pd); else passed++;
        exp_p = 8'd15;
    endtask

    task automatic test_random;
        int done_at, busy_cnt;
        logic [7:0] pd;
        bit held;
        logic [3:0] av, bv;
        for (int i = 0; i < 20; i++) begin
            av = 4'($urandom_range(0, 15));
            bv = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch(av, bv);
            watch(exp_p, done_at, busy_cnt, pd, held);
            checks++; if (done_at != 4 || busy_cnt != 5)
                $display("FAIL rand%0d_timing got done_at %0d busy %0d exp 4 5", i, done_at, busy_cnt); else passed++;
            checks++; if (pd !== 8'(av * bv)) $display("FAIL rand%0d_product %0d*%0d got %0d exp %0d", i, av, bv, pd, av * bv); else passed++;
            checks++; if (!held) $display("FAIL rand%0d_p_held got 0 exp 1", i); else passed++;
            exp_p = 8'(av * bv);
        end
    endtask

    task automatic test_sweep;
        int last = -1;
        int waited;
        logic [7:0] idx;
        @(negedge clk);
        bus.a = 4'd0;
        bus.b = 4'd0;
        bus.start = 1'b1;
        for (int n = 0; n < 256; n++) begin
            waited = 0;
            @(negedge clk);
            while (!bus.done && waited < 12) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (!bus.done) begin
                $display("FAIL sweep_timeout n=%0d got no done exp done", n);
                break;
            end else passed++;
            checks++; if (bus.p !== 8'((n / 16) * (n % 16)))
                $display("FAIL sweep_product %0d*%0d got %0d exp %0d", n / 16, n % 16, bus.p, (n / 16) * (n % 16)); else passed++;
            if (last >= 0) begin
                checks++; if (cyc - last != 6) $display("FAIL sweep_spacing n=%0d got %0d exp 6", n, cyc - last); else passed++;
            end
            last = cyc;
            if (n < 255) begin
                idx = 8'(n + 1);
                bus.a = idx[7:4];
                bus.b = idx[3:0];
            end else bus.start = 1'b0;
        end
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = 4'd0;
        bus.b = 4'd0;
        test_reset;
        test_max;
        test_pair_hold;
        test_ignore_start;
        test_abort;
        test_random;
        test_sweep;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
